// File: rtl/checkdigit_pkg.sv
// Shared types and constants for the check-digit scheduler.
package checkdigit_pkg;

    localparam int FRAME_LEN = 15;
    localparam int DIGIT_W   = 4;

    // The engine reports a computed check digit of 0 as this code.
    localparam logic [DIGIT_W-1:0] ZERO_CODE = 4'd15;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        FEED,
        WAIT,
        RESP
    } state_t;

endpackage

// File: rtl/checkdigit_rr_arb.sv
// Combinational round-robin picker: first requester at or above rr_ptr+1, wrapping.
module checkdigit_rr_arb #(
    parameter int N_REQ = 4,
    parameter int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] rr_ptr,
    output logic [N_REQ-1:0] win_onehot,
    output logic [IDX_W-1:0] win_idx,
    output logic             win_any
);

    localparam logic [IDX_W:0] N_W = (IDX_W+1)'(N_REQ);

    logic [IDX_W-1:0] cand_idx [N_REQ];
    logic [N_REQ-1:0] cand_hit;

    // Candidate gi is the requester gi+1 places after the pointer, modulo N_REQ.
    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_cand
            logic [IDX_W:0] sum;
            assign sum          = {1'b0, rr_ptr} + (IDX_W+1)'(gi + 1);
            assign cand_idx[gi] = (sum >= N_W) ? IDX_W'(sum - N_W) : sum[IDX_W-1:0];
            assign cand_hit[gi] = req[cand_idx[gi]];
        end
    endgenerate

    // Scan from the farthest candidate down so the nearest hit wins.
    always_comb begin
        win_idx = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (cand_hit[i]) begin
                win_idx = cand_idx[i];
            end
        end
        win_any    = |req;
        win_onehot = win_any ? ({{(N_REQ-1){1'b0}}, 1'b1} << win_idx) : '0;
    end

endmodule

// File: rtl/checkdigit_sched.sv
// Shares one serial Luhn engine between N_REQ requesters: round-robin grant,
// frame buffering (gaps allowed), contiguous replay, tagged response.
module checkdigit_sched
    import checkdigit_pkg::*;
#(
    parameter int N_REQ     = 4,
    parameter int FRAME_LEN = checkdigit_pkg::FRAME_LEN,
    parameter int TIMEOUT   = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req,
    input  logic [4*N_REQ-1:0]       req_num,
    input  logic [N_REQ-1:0]         req_dvalid,
    output logic [N_REQ-1:0]         gnt,
    output logic [3:0]               eng_in_num,
    output logic                     eng_in_valid,
    input  logic                     eng_out_valid,
    input  logic [3:0]               eng_out,
    output logic                     rsp_valid,
    output logic [$clog2(N_REQ)-1:0] rsp_id,
    output logic [3:0]               rsp_digit,
    output logic                     rsp_err
);

    localparam int IDX_W = $clog2(N_REQ);
    localparam int PTR_W = $clog2(FRAME_LEN + 1);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    state_t               state_reg;
    logic [IDX_W-1:0]     owner_reg;
    logic [IDX_W-1:0]     rr_ptr_reg;
    logic [PTR_W-1:0]     wptr_reg;
    logic [PTR_W-1:0]     rptr_reg;
    logic [CNT_W-1:0]     wait_cnt_reg;
    logic [N_REQ-1:0]     gnt_reg;
    logic                 eng_in_valid_reg;
    logic [DIGIT_W-1:0]   eng_in_num_reg;
    logic                 rsp_valid_reg;
    logic [IDX_W-1:0]     rsp_id_reg;
    logic [DIGIT_W-1:0]   rsp_digit_reg;
    logic                 rsp_err_reg;

    logic [DIGIT_W-1:0]   buf_mem [FRAME_LEN];
    logic [DIGIT_W-1:0]   digit_slice [N_REQ];

    logic [N_REQ-1:0]     arb_onehot;
    logic [IDX_W-1:0]     arb_idx;
    logic                 arb_any;

    logic                 own_req;
    logic                 own_dv;
    logic [DIGIT_W-1:0]   own_digit;
    logic                 load_fire;

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_slice
            assign digit_slice[gi] = req_num[gi*4 +: 4];
        end
    endgenerate

    assign own_req   = req[owner_reg];
    assign own_dv    = req_dvalid[owner_reg];
    assign own_digit = digit_slice[owner_reg];
    assign load_fire = (state_reg == LOAD) && own_req && own_dv;

    checkdigit_rr_arb #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_arb (
        .req        (req),
        .rr_ptr     (rr_ptr_reg),
        .win_onehot (arb_onehot),
        .win_idx    (arb_idx),
        .win_any    (arb_any)
    );

    // Frame buffer write port: owner's digits land in arrival order.
    always_ff @(posedge clk) begin
        if (load_fire) begin
            buf_mem[wptr_reg] <= own_digit;
        end
    end

    // Scheduler FSM with registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg        <= IDLE;
            owner_reg        <= '0;
            rr_ptr_reg       <= IDX_W'(N_REQ - 1);
            wptr_reg         <= '0;
            rptr_reg         <= '0;
            wait_cnt_reg     <= '0;
            gnt_reg          <= '0;
            eng_in_valid_reg <= 1'b0;
            eng_in_num_reg   <= '0;
            rsp_valid_reg    <= 1'b0;
            rsp_id_reg       <= '0;
            rsp_digit_reg    <= '0;
            rsp_err_reg      <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (arb_any) begin
                        owner_reg  <= arb_idx;
                        rr_ptr_reg <= arb_idx;
                        gnt_reg    <= arb_onehot;
                        wptr_reg   <= '0;
                        state_reg  <= LOAD;
                    end
                end
                LOAD: begin
                    if (!own_req) begin
                        // Owner withdrew mid-frame: discard it silently.
                        gnt_reg   <= '0;
                        wptr_reg  <= '0;
                        state_reg <= IDLE;
                    end else if (own_dv) begin
                        if (wptr_reg == PTR_W'(FRAME_LEN - 1)) begin
                            gnt_reg   <= '0;
                            wptr_reg  <= '0;
                            rptr_reg  <= '0;
                            state_reg <= FEED;
                        end else begin
                            wptr_reg <= wptr_reg + 1'b1;
                        end
                    end
                end
                FEED: begin
                    eng_in_valid_reg <= 1'b1;
                    eng_in_num_reg   <= buf_mem[rptr_reg];
                    if (rptr_reg == PTR_W'(FRAME_LEN - 1)) begin
                        rptr_reg     <= '0;
                        wait_cnt_reg <= '0;
                        state_reg    <= WAIT;
                    end else begin
                        rptr_reg <= rptr_reg + 1'b1;
                    end
                end
                WAIT: begin
                    eng_in_valid_reg <= 1'b0;
                    eng_in_num_reg   <= '0;
                    if (eng_out_valid) begin
                        rsp_valid_reg <= 1'b1;
                        rsp_id_reg    <= owner_reg;
                        rsp_digit_reg <= (eng_out == ZERO_CODE) ? '0 : eng_out;
                        rsp_err_reg   <= 1'b0;
                        state_reg     <= RESP;
                    end else if (wait_cnt_reg == CNT_W'(TIMEOUT - 1)) begin
                        rsp_valid_reg <= 1'b1;
                        rsp_id_reg    <= owner_reg;
                        rsp_digit_reg <= '0;
                        rsp_err_reg   <= 1'b1;
                        state_reg     <= RESP;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg + 1'b1;
                    end
                end
                RESP: begin
                    // Only the strobe drops; the response fields stay readable.
                    rsp_valid_reg <= 1'b0;
                    wptr_reg      <= '0;
                    rptr_reg      <= '0;
                    wait_cnt_reg  <= '0;
                    state_reg     <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign gnt          = gnt_reg;
    assign eng_in_valid = eng_in_valid_reg;
    assign eng_in_num   = eng_in_num_reg;
    assign rsp_valid    = rsp_valid_reg;
    assign rsp_id       = rsp_id_reg;
    assign rsp_digit    = rsp_digit_reg;
    assign rsp_err      = rsp_err_reg;

endmodule
